// File: rtl/int_priority_ctrl.sv
// Nesting priority interrupt controller: edge-latched break lines, fixed priority 3>2>1,
// return-address/level stack unwound by eret. Define INT_NEST_EN to allow preemption of a running ISR.
module int_priority_ctrl #(
    parameter logic [31:0] ISR1_ADDR = 32'h0000_0100,
    parameter logic [31:0] ISR2_ADDR = 32'h0000_0200,
    parameter logic [31:0] ISR3_ADDR = 32'h0000_0300
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        break1,
    input  logic        break2,
    input  logic        break3,
    input  logic        take_ok,
    input  logic [31:0] epc_in,
    input  logic        eret,
    output logic        interrupt,
    output logic [31:0] isr_entry,
    output logic [31:0] epc_out,
    output logic        IW1,
    output logic        IW2,
    output logic        IW3,
    output logic        ir1_sig,
    output logic        ir2_sig,
    output logic        ir3_sig,
    output logic [1:0]  int_level
);

`ifdef INT_NEST_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic {ST_IDLE = 1'b0, ST_SERVICE = 1'b1} st_e;

    logic [2:0]  brk_now, rise;
    logic [2:0]  brk_q, brk_d, iw_q, iw_d, ir_q, ir_d;
    logic [1:0]  level_q, level_d, sp_q, sp_d;
    logic        interrupt_q, interrupt_d;
    logic [31:0] isr_entry_q, isr_entry_d;
    logic [31:0] stk_addr_q [DEPTH];
    logic [31:0] stk_addr_d [DEPTH];
    logic [1:0]  stk_lvl_q [DEPTH];
    logic [1:0]  stk_lvl_d [DEPTH];
    st_e         st_q, st_d;

    logic [1:0]  win;
    logic [2:0]  win_oh, lvl_oh;
    logic [31:0] top_addr;
    logic [1:0]  top_lvl;
    logic        nest_ok, req, pop;

    always_comb begin
        brk_now = {break3, break2, break1};
        rise    = brk_now & ~brk_q;

        win    = 2'd0;
        win_oh = 3'b000;
        if (iw_q[2]) begin
            win    = 2'd3;
            win_oh = 3'b100;
        end else if (iw_q[1]) begin
            win    = 2'd2;
            win_oh = 3'b010;
        end else if (iw_q[0]) begin
            win    = 2'd1;
            win_oh = 3'b001;
        end

        case (level_q)
            2'd1:    lvl_oh = 3'b001;
            2'd2:    lvl_oh = 3'b010;
            2'd3:    lvl_oh = 3'b100;
            default: lvl_oh = 3'b000;
        endcase

        // sp_q counts occupied entries, so the top lives at sp_q-1; an empty stack reads as 0
        top_addr = 32'd0;
        top_lvl  = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(sp_q) == i + 1) begin
                top_addr = stk_addr_q[i];
                top_lvl  = stk_lvl_q[i];
            end
        end

`ifdef INT_NEST_EN
        nest_ok = 1'b1;
`else
        nest_ok = (level_q == 2'd0);
`endif
        // ~interrupt_q enforces at least one idle cycle between consecutive takes
        req = (win > level_q) && take_ok && !eret && !interrupt_q && nest_ok;
        pop = eret && (level_q != 2'd0);
    end

    always_comb begin
        brk_d       = brk_now;
        iw_d        = iw_q;
        ir_d        = ir_q;
        level_d     = level_q;
        sp_d        = sp_q;
        interrupt_d = 1'b0;
        isr_entry_d = isr_entry_q;
        stk_addr_d  = stk_addr_q;
        stk_lvl_d   = stk_lvl_q;
        st_d        = st_q;

        if (req) begin
            interrupt_d = 1'b1;
            case (win)
                2'd1:    isr_entry_d = ISR1_ADDR;
                2'd2:    isr_entry_d = ISR2_ADDR;
                2'd3:    isr_entry_d = ISR3_ADDR;
                default: isr_entry_d = isr_entry_q;
            endcase
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(sp_q) == i) begin
                    stk_addr_d[i] = epc_in;
                    stk_lvl_d[i]  = level_q;
                end
            end
            sp_d    = sp_q + 2'd1;
            level_d = win;
            iw_d    = iw_q & ~win_oh;
            ir_d    = ir_q | win_oh;
        end else if (pop) begin
            sp_d    = sp_q - 2'd1;
            level_d = top_lvl;
            ir_d    = ir_q & ~lvl_oh;
        end

        // A new rise re-arms a source even in the cycle its previous request is taken
        iw_d = iw_d | rise;

        case (st_q)
            ST_IDLE:    if (req) st_d = ST_SERVICE;
            ST_SERVICE: if (pop && sp_q == 2'd1) st_d = ST_IDLE;
            default:    st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            brk_q       <= 3'b000;
            iw_q        <= 3'b000;
            ir_q        <= 3'b000;
            level_q     <= 2'd0;
            sp_q        <= 2'd0;
            interrupt_q <= 1'b0;
            isr_entry_q <= 32'd0;
            st_q        <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                stk_addr_q[i] <= 32'd0;
                stk_lvl_q[i]  <= 2'd0;
            end
        end else begin
            brk_q       <= brk_d;
            iw_q        <= iw_d;
            ir_q        <= ir_d;
            level_q     <= level_d;
            sp_q        <= sp_d;
            interrupt_q <= interrupt_d;
            isr_entry_q <= isr_entry_d;
            st_q        <= st_d;
            stk_addr_q  <= stk_addr_d;
            stk_lvl_q   <= stk_lvl_d;
        end
    end

    assign interrupt = interrupt_q;
    assign isr_entry = isr_entry_q;
    assign epc_out   = top_addr;
    assign IW1       = iw_q[0];
    assign IW2       = iw_q[1];
    assign IW3       = iw_q[2];
    assign ir1_sig   = ir_q[0];
    assign ir2_sig   = ir_q[1];
    assign ir3_sig   = ir_q[2];
    assign int_level = level_q;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed bench for int_priority_ctrl; status vector is {IW3,IW2,IW1,ir3,ir2,ir1,int_level}.
module tb_int_priority_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic        break1, break2, break3, take_ok, eret;
    logic [31:0] epc_in;
    logic        interrupt;
    logic [31:0] isr_entry, epc_out;
    logic        IW1, IW2, IW3, ir1_sig, ir2_sig, ir3_sig;
    logic [1:0]  int_level;
    logic [7:0]  stat;

    int n_tests = 0;
    int n_fail  = 0;

    assign stat = {IW3, IW2, IW1, ir3_sig, ir2_sig, ir1_sig, int_level};

    always #5 clk = ~clk;

    int_priority_ctrl dut (
        .clk(clk), .RST(RST),
        .break1(break1), .break2(break2), .break3(break3),
        .take_ok(take_ok), .epc_in(epc_in), .eret(eret),
        .interrupt(interrupt), .isr_entry(isr_entry), .epc_out(epc_out),
        .IW1(IW1), .IW2(IW2), .IW3(IW3),
        .ir1_sig(ir1_sig), .ir2_sig(ir2_sig), .ir3_sig(ir3_sig),
        .int_level(int_level)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        RST = 1'b0;
        break1 = 1'b0; break2 = 1'b0; break3 = 1'b0;
        eret = 1'b0; take_ok = 1'b1; epc_in = 32'd0;
        #2;
        RST = 1'b1;
        tick;
    endtask

    task test_reset;
        RST = 1'b0;
        break1 = 1'b0; break2 = 1'b0; break3 = 1'b0;
        eret = 1'b0; take_ok = 1'b1; epc_in = 32'd0;
        tick;
        n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b want 0", interrupt); end
        n_tests++; if (isr_entry !== 32'd0) begin n_fail++; $display("FAIL rst_isr: got %h want 0", isr_entry); end
        n_tests++; if (epc_out !== 32'd0) begin n_fail++; $display("FAIL rst_epc: got %h want 0", epc_out); end
        n_tests++; if (stat !== 8'b000_000_00) begin n_fail++; $display("FAIL rst_stat: got %b want 00000000", stat); end
        RST = 1'b1;
        tick;
    endtask

    task test_take2;
        do_reset;
        epc_in = 32'h40; break2 = 1'b1;
        tick;
        n_tests++; if (stat !== 8'b010_000_00 || interrupt !== 1'b0) begin n_fail++; $display("FAIL t2_pend: stat=%b int=%b want 01000000 int=0", stat, interrupt); end
        tick;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h200) begin n_fail++; $display("FAIL t2_take: int=%b isr=%h want 1 00000200", interrupt, isr_entry); end
        n_tests++; if (stat !== 8'b000_010_10 || epc_out !== 32'h40) begin n_fail++; $display("FAIL t2_state: stat=%b epc=%h want 00001010 00000040", stat, epc_out); end
        break2 = 1'b0;
        tick;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b000_010_10 || isr_entry !== 32'h200) begin n_fail++; $display("FAIL t2_hold: int=%b stat=%b isr=%h want 0 00001010 00000200", interrupt, stat, isr_entry); end
        eret = 1'b1;
        tick;
        eret = 1'b0;
        n_tests++; if (stat !== 8'b000_000_00 || epc_out !== 32'd0) begin n_fail++; $display("FAIL t2_eret: stat=%b epc=%h want 00000000 0", stat, epc_out); end
    endtask

`ifdef INT_NEST_EN
    task test_nested;
        do_reset;
        epc_in = 32'h40; break1 = 1'b1;
        tick;
        tick;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h100 || epc_out !== 32'h40 || stat !== 8'b000_001_01) begin n_fail++; $display("FAIL nest_l1: int=%b isr=%h epc=%h stat=%b want 1 100 40 00000101", interrupt, isr_entry, epc_out, stat); end
        break1 = 1'b0; epc_in = 32'h108; break3 = 1'b1;
        tick;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b100_001_01) begin n_fail++; $display("FAIL nest_pend3: int=%b stat=%b want 0 10000101", interrupt, stat); end
        tick;
        break3 = 1'b0;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h300 || epc_out !== 32'h108 || stat !== 8'b000_101_11) begin n_fail++; $display("FAIL nest_pre: int=%b isr=%h epc=%h stat=%b want 1 300 108 00010111", interrupt, isr_entry, epc_out, stat); end
        tick;
        eret = 1'b1;
        tick;
        eret = 1'b0;
        n_tests++; if (epc_out !== 32'h40 || stat !== 8'b000_001_01) begin n_fail++; $display("FAIL nest_eret1: epc=%h stat=%b want 40 00000101", epc_out, stat); end
        tick;
        eret = 1'b1;
        tick;
        eret = 1'b0;
        n_tests++; if (epc_out !== 32'd0 || stat !== 8'b000_000_00 || interrupt !== 1'b0) begin n_fail++; $display("FAIL nest_eret2: epc=%h stat=%b int=%b want 0 0 0", epc_out, stat, interrupt); end
    endtask
`else
    task test_no_nest;
        do_reset;
        epc_in = 32'h40; break1 = 1'b1;
        tick;
        tick;
        break1 = 1'b0; break3 = 1'b1; epc_in = 32'h108;
        tick;
        n_tests++; if (stat !== 8'b100_001_01) begin n_fail++; $display("FAIL nn_pend: stat=%b want 10000101", stat); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_tests++; if (interrupt !== 1'b0 || stat !== 8'b100_001_01 || epc_out !== 32'h40) begin n_fail++; $display("FAIL nn_wait%0d: int=%b stat=%b epc=%h want 0 10000101 40", i, interrupt, stat, epc_out); end
        end
        break3 = 1'b0; eret = 1'b1;
        tick;
        eret = 1'b0;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b100_000_00) begin n_fail++; $display("FAIL nn_pop: int=%b stat=%b want 0 10000000", interrupt, stat); end
        tick;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h300 || stat !== 8'b000_100_11 || epc_out !== 32'h108) begin n_fail++; $display("FAIL nn_take3: int=%b isr=%h stat=%b epc=%h want 1 300 00010011 108", interrupt, isr_entry, stat, epc_out); end
    endtask
`endif

    task test_simul;
        do_reset;
        epc_in = 32'h80; break1 = 1'b1; break3 = 1'b1;
        tick;
        n_tests++; if (stat !== 8'b101_000_00) begin n_fail++; $display("FAIL sim_pend: stat=%b want 10100000", stat); end
        tick;
        break1 = 1'b0; break3 = 1'b0;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h300 || stat !== 8'b001_100_11 || epc_out !== 32'h80) begin n_fail++; $display("FAIL sim_take3: int=%b isr=%h stat=%b epc=%h want 1 300 00110011 80", interrupt, isr_entry, stat, epc_out); end
        tick;
        tick;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b001_100_11) begin n_fail++; $display("FAIL sim_iw1_wait: int=%b stat=%b want 0 00110011", interrupt, stat); end
        eret = 1'b1;
        tick;
        eret = 1'b0;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b001_000_00 || epc_out !== 32'd0) begin n_fail++; $display("FAIL sim_pop: int=%b stat=%b epc=%h want 0 00100000 0", interrupt, stat, epc_out); end
        tick;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h100 || stat !== 8'b000_001_01) begin n_fail++; $display("FAIL sim_take1: int=%b isr=%h stat=%b want 1 100 00000101", interrupt, isr_entry, stat); end
    endtask

    task test_take_ok;
        int n_int;
        do_reset;
        take_ok = 1'b0; break2 = 1'b1; epc_in = 32'h44;
        tick;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_tests++; if (interrupt !== 1'b0 || stat !== 8'b010_000_00) begin n_fail++; $display("FAIL tok_hold%0d: int=%b stat=%b want 0 01000000", i, interrupt, stat); end
        end
        take_ok = 1'b1;
        tick;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h200 || stat !== 8'b000_010_10) begin n_fail++; $display("FAIL tok_fire: int=%b isr=%h stat=%b want 1 200 00001010", interrupt, isr_entry, stat); end
        n_int = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (interrupt === 1'b1) n_int++;
        end
        n_tests++; if (n_int != 0 || stat !== 8'b000_010_10) begin n_fail++; $display("FAIL tok_single: extra takes=%0d stat=%b want 0 00001010", n_int, stat); end
        break2 = 1'b0;
    endtask

    task test_eret_collide;
        do_reset;
        epc_in = 32'h40; break1 = 1'b1;
        tick;
        tick;
        break1 = 1'b0; take_ok = 1'b0; break3 = 1'b1;
        tick;
        tick;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b100_001_01) begin n_fail++; $display("FAIL col_pend: int=%b stat=%b want 0 10000101", interrupt, stat); end
        take_ok = 1'b1; eret = 1'b1;
        #1;
        n_tests++; if (epc_out !== 32'h40) begin n_fail++; $display("FAIL col_prepop_epc: got %h want 40", epc_out); end
        tick;
        eret = 1'b0;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b100_000_00 || epc_out !== 32'd0) begin n_fail++; $display("FAIL col_pop: int=%b stat=%b epc=%h want 0 10000000 0", interrupt, stat, epc_out); end
        tick;
        break3 = 1'b0;
        n_tests++; if (interrupt !== 1'b1 || isr_entry !== 32'h300 || stat !== 8'b000_100_11 || epc_out !== 32'h40) begin n_fail++; $display("FAIL col_take: int=%b isr=%h stat=%b epc=%h want 1 300 00010011 40", interrupt, isr_entry, stat, epc_out); end
    endtask

    task test_eret_idle;
        do_reset;
        epc_in = 32'h55; eret = 1'b1;
        tick;
        eret = 1'b0;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b000_000_00 || epc_out !== 32'd0 || isr_entry !== 32'd0) begin n_fail++; $display("FAIL idle_eret: int=%b stat=%b epc=%h isr=%h want all 0", interrupt, stat, epc_out, isr_entry); end
        tick;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b000_000_00) begin n_fail++; $display("FAIL idle_after: int=%b stat=%b want 0 0", interrupt, stat); end
    endtask

    task test_reset_mid;
        do_reset;
        epc_in = 32'h40; break2 = 1'b1;
        tick;
        tick;
        break2 = 1'b0; break1 = 1'b1;
        tick;
        n_tests++; if (stat !== 8'b001_010_10 || epc_out !== 32'h40) begin n_fail++; $display("FAIL mid_pre: stat=%b epc=%h want 00101010 40", stat, epc_out); end
        #2;
        RST = 1'b0;
        #1;
        n_tests++; if (interrupt !== 1'b0 || isr_entry !== 32'd0 || epc_out !== 32'd0 || stat !== 8'b000_000_00) begin n_fail++; $display("FAIL mid_async: int=%b isr=%h epc=%h stat=%b want all 0", interrupt, isr_entry, epc_out, stat); end
        break1 = 1'b0;
        #1;
        RST = 1'b1;
        tick;
        tick;
        n_tests++; if (interrupt !== 1'b0 || stat !== 8'b000_000_00) begin n_fail++; $display("FAIL mid_after: int=%b stat=%b want 0 0", interrupt, stat); end
    endtask

    initial begin
        test_reset;
        test_take2;
`ifdef INT_NEST_EN
        test_nested;
`else
        test_no_nest;
`endif
        test_simul;
        test_take_ok;
        test_eret_collide;
        test_eret_idle;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_priority_ctrl.md
# int_priority_ctrl

Nesting priority interrupt controller for the 5-stage pipelined CPU. It latches rising edges on three external break lines and arbitrates them by fixed priority (3 > 2 > 1). It issues a one-cycle `interrupt` redirect with the ISR entry address to IF and the pipeline registers. It keeps a return-address/level stack so that a higher-priority source can preempt a running ISR, and it unwinds that stack one level per `eret`.

## Interface
Parameters:
- `ISR1_ADDR`, default 32'h0000_0100: entry address for source 1
- `ISR2_ADDR`, default 32'h0000_0200: entry address for source 2
- `ISR3_ADDR`, default 32'h0000_0300: entry address for source 3

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `RST`  in  1  asynchronous, active-low reset
- `break1`, `break2`, `break3`  in  1 each  raw interrupt lines, synchronous to `clk`; level is ignored, only the rising edge counts
- `take_ok`  in  1  pipeline can accept a redirect this cycle (low on stall, halt or jump flush)
- `epc_in`  in  32  restart address of the oldest uncommitted instruction, valid every cycle
- `eret`  in  1  one-cycle pulse when an eret reaches the EX/MEM stage
- `interrupt`  out  1  registered one-cycle redirect pulse
- `isr_entry`  out  32  entry address, valid while `interrupt`=1, held afterwards
- `epc_out`  out  32  return address of the running ISR (top of stack)
- `IW1`, `IW2`, `IW3`  out  1 each  source pending (waiting)
- `ir1_sig`, `ir2_sig`, `ir3_sig`  out  1 each  source is on the service stack
- `int_level`  out  2  current service level (0 = user code)

## Operation
- Edge detect: `brk_q` registers each break line. `rise_k = break_k & ~brk_q_k`. A rise sets pending bit `IWk`; a rise on a source that is already pending is absorbed (no counting).
- Arbitration (combinational, on registered state): `win` = highest k with `IWk`=1. `req` = `win` > `int_level` & `take_ok` & ~`eret` & ~`interrupt`. The last term gives a minimum 1-cycle gap between takes.
- Take (on `req`, next edge):
  - `interrupt`<=1 for 1 cycle; `isr_entry`<=`ISRk_ADDR`.
  - Push {`epc_in`, old `int_level`} onto the stack; `int_level`<=k.
  - Clear `IWk`, set `irk_sig`.
  - A rise on the same source in the same cycle re-sets `IWk` (the rise wins over the clear).
- Return (on `eret`, next edge):
  - Pop the stack: `int_level`<=saved level; clear `ir<old level>_sig`.
  - `epc_out`<=new top address, or 0 when the stack becomes empty.
  - `epc_out` is valid for the IF redirect in the same cycle `eret` is high, because it still shows the pre-pop value.
- `eret` with an empty stack (level 0): ignored, no state change.
- Stack depth is 3. Levels on the stack are strictly increasing, so the stack cannot overflow.
- A source equal to or lower than `int_level` stays pending and is taken after the eret unwinds below its level.
- State machine `st`:
  - IDLE (level 0) → SERVICE on take.
  - SERVICE → SERVICE on nested take or on an eret that leaves depth ≥1.
  - SERVICE → IDLE on the eret that empties the stack.

## Timing
- Reset (RST=0, asynchronous):
  - `interrupt`=0, `isr_entry`=0, `epc_out`=0.
  - `IW*`=0, `ir*_sig`=0, `int_level`=0, stack cleared, `brk_q`=0, `st`=IDLE.
- Reset mid-service discards all pending and stacked state.
- Latency:
  - Break rise sampled at edge n → `IWk`=1 after edge n.
  - If `req` holds → `interrupt`=1 after edge n+1, i.e. 2 cycles from the rise.
- `take_ok`=0 delays the take. `IWk` holds, and the take fires on the first cycle `take_ok`=1.
- Simultaneous `eret` and a pending winner: the eret pops first, and the winner is re-arbitrated against the popped level in the following cycle.
- Simultaneous rises on several sources: all are latched, and they are taken highest-first, each in its own cycle at least 2 apart.

## Configuration
- `INT_NEST_EN` defined:
  - Preemption as described; 3-entry stack.
- `INT_NEST_EN` undefined:
  - `req` additionally requires `int_level`=0.
  - Stack reduced to 1 entry; no interrupt is taken inside an ISR.
  - Pending sources wait for the eret, then the highest is taken.

## Test plan
- Reset, then a rise on `break2` with `take_ok`=1 and `epc_in`=0x40 → `IW2` for 1 cycle, then `interrupt`=1 for exactly 1 cycle, `isr_entry`=0x200, `int_level`=2, `ir2_sig`=1, `epc_out`=0x40.
- In service at level 1 (`epc_out`=0x40), rise on `break3` with `epc_in`=0x108 → preempt to `isr_entry`=0x300, `epc_out`=0x108. First `eret` → `int_level`=1, `epc_out`=0x40. Second `eret` → level 0, `epc_out`=0.
- Rises on `break1` and `break3` in the same cycle → `ISR3` taken first. `IW1` stays 1 until the eret returns to level 0, then `isr_entry`=0x100.
- A pending `break2` with `take_ok`=0 for 5 cycles → no `interrupt`; it fires 1 cycle after `take_ok` rises. A `break2` held high for 10 cycles produces a single take.
- `eret` coinciding with a pending higher source → pop happens first, take follows 1 cycle later. `eret` at level 0 → no change. Assert RST during level 2 → all outputs 0 asynchronously.
- Without `INT_NEST_EN`: at level 1, rise on `break3` → no take until `eret`, then `isr_entry`=0x300.
